// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with an integrated issue scoreboard.
// Two combinational read ports, one writeback port, optional same-cycle
// writeback-to-read bypass, per-register busy bits and an issue stall.
//
// Issue handshake: i_issue_valid is the request and ~o_stall is the ready.
// An issue is accepted only on a rising edge where i_issue_valid=1 and
// o_stall=0. A stalled request leaves every piece of state untouched, and
// upstream holds it until it is accepted. Writeback has no back-pressure.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_rd_wren,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_stall,
  output logic [NREG-1:0] o_busy_vec,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data,
  output logic            o_err
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic            wb_valid;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] issue_set;

  // A writeback to x0 is discarded entirely (data, busy and error tracking).
  assign wb_valid = i_rd_wren && (i_rd_addr != '0);

  // Decode the writeback into per-register clear strobes; x0 never clears.
  always_comb begin
    wb_clr = '0;
    for (int k = 1; k < NREG; k++) begin
      wb_clr[k] = wb_valid && (i_rd_addr == AW'(k));
    end
  end

  assign eff_busy = busy_q & ~wb_clr;

  // Issue hazard: either source or the destination still pending after this
  // cycle's writeback has been taken into account.
  always_comb begin
    o_stall = i_issue_valid &&
              (eff_busy[i_rs1_addr] || eff_busy[i_rs2_addr] || eff_busy[i_issue_rd]);
  end

  // Reservation made by an accepted issue with a real destination.
  always_comb begin
    issue_set = '0;
    if (i_issue_valid && !o_stall && (i_issue_rd != '0)) begin
      issue_set[i_issue_rd] = 1'b1;
    end
  end

  // Next busy state: writeback frees, an accepted issue reserves; set wins.
  always_comb begin
    busy_d    = (busy_q & ~wb_clr) | issue_set;
    busy_d[0] = 1'b0;
  end

  // Sticky error when a writeback hits a register nobody reserved.
  always_comb begin
    err_d = err_q || (wb_valid && !busy_q[i_rd_addr]);
  end

  // Next register contents; x0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid) begin
      regs_d[i_rd_addr] = i_rd_data;
    end
    regs_d[0] = '0;
  end

  // State registers; reset has priority over writeback and issue.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Read port 1: zero for x0, else bypassed writeback data, else stored value.
  always_comb begin
    if (i_rs1_addr == '0) begin
      o_rs1_data = '0;
    end else if (BYPASS && i_rd_wren && (i_rd_addr == i_rs1_addr)) begin
      o_rs1_data = i_rd_data;
    end else begin
      o_rs1_data = regs_q[i_rs1_addr];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    if (i_rs2_addr == '0) begin
      o_rs2_data = '0;
    end else if (BYPASS && i_rd_wren && (i_rd_addr == i_rs2_addr)) begin
      o_rs2_data = i_rd_data;
    end else begin
      o_rs2_data = regs_q[i_rs2_addr];
    end
  end

  // Debug port always shows the stored value, never the bypass.
  always_comb begin
    if (i_dbg_addr == '0) begin
      o_dbg_data = '0;
    end else begin
      o_dbg_data = regs_q[i_dbg_addr];
    end
  end

  assign o_busy_vec = busy_q;
  assign o_err      = err_q;

endmodule
